// File: rtl/arm_ctrl_pkg.sv
// Shared ARM-control definitions: CSPI PHY state encoding, default divider, MAC trailer byte.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arm_ctrl_pkg;

   // CSPI PHY states; the encoding is fixed because other ARM-control blocks decode it.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4,
      ST_DONE  = 3'd5
   } cspi_state_e;

   // Default SCK half-period in clk_sys cycles.
   localparam int unsigned CSPI_DIV_DEF = 4;

   // Fifth byte of every MAC command.
   localparam logic [7:0] MAC_TRAILER_BYTE = 8'hFF;

endpackage

// File: rtl/arm_ctrl_cspi_if.sv
// MAC <-> CSPI PHY byte handshake: fire/set_data in, done/get_q/get_vld/busy back.
// Latency: wires only.
// Backpressure: none; the MAC must wait for done_cspi before the next fire.
// Ports: master = MAC side, slave = PHY side.
interface arm_ctrl_cspi_if;
   logic       fire_cspi;
   logic [7:0] set_data;
   logic       done_cspi;
   logic [7:0] get_q;
   logic       get_vld;
   logic       busy;

   modport master (
      output fire_cspi, set_data,
      input  done_cspi, get_q, get_vld, busy
   );

   modport slave (
      input  fire_cspi, set_data,
      output done_cspi, get_q, get_vld, busy
   );
endinterface

// File: rtl/cspi_tick_gen.sv
// SCK phase timer: counts 0..DIV-1 and flags the last cycle of each phase.
// Latency: half_end_o is combinational from the registered count.
// Backpressure: none; clr_i holds the count at zero.
// Ports: clk_sys, rst_n, clr_i (sync clear), half_end_o (last cycle of phase).
module cspi_tick_gen #(
   parameter int unsigned DIV = 4
) (
   input  logic clk_sys,
   input  logic rst_n,
   input  logic clr_i,
   output logic half_end_o
);

   localparam logic [7:0] DCNT_LAST = 8'(DIV - 1);

   logic [7:0] dcnt_q;
   logic [7:0] dcnt_d;

   assign half_end_o = (dcnt_q == DCNT_LAST);

   always_comb begin
      dcnt_d = dcnt_q + 8'd1;
      if (clr_i || half_end_o) begin
         dcnt_d = 8'd0;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         dcnt_q <= 8'd0;
      end else begin
         dcnt_q <= dcnt_d;
      end
   end

endmodule

// File: rtl/arm_ctrl_cspi.sv
// Byte-level CSPI master PHY: one 8-bit mode-0 MSB-first full-duplex transfer per fire.
// Latency: done_cspi/get_vld 1+19*DIV cycles after the accepted fire; get_q one cycle later.
// Backpressure: fire ignored outside IDLE (no queueing); busy high while not IDLE.
// Ports: clk_sys, rst_n, mac (slave modport), cspi_csn/cspi_sck/cspi_mosi out, cspi_miso in.
module arm_ctrl_cspi
   import arm_ctrl_pkg::*;
#(
   parameter int unsigned DIV = CSPI_DIV_DEF
) (
   input  logic              clk_sys,
   input  logic              rst_n,
   arm_ctrl_cspi_if.slave    mac,
   output logic              cspi_csn,
   output logic              cspi_sck,
   output logic              cspi_mosi,
   input  logic              cspi_miso
);

   cspi_state_e state_q;
   logic [7:0]  tx_sr_q;
   logic [7:0]  rx_sr_q;
   logic [7:0]  get_q_q;
   logic [2:0]  bcnt_q;
   logic        csn_q;
   logic        sck_q;
   logic        done_q;
   logic        busy_q;

   logic        half_end;
   logic        tick_clr;

   // Timer is parked at zero outside the timed states so every phase starts aligned.
   assign tick_clr = (state_q == ST_IDLE) || (state_q == ST_DONE);

   cspi_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .clk_sys    (clk_sys),
      .rst_n      (rst_n),
      .clr_i      (tick_clr),
      .half_end_o (half_end)
   );

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         tx_sr_q <= 8'h00;
         rx_sr_q <= 8'h00;
         get_q_q <= 8'h00;
         bcnt_q  <= 3'd0;
         csn_q   <= 1'b1;
         sck_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (mac.fire_cspi) begin
                  tx_sr_q <= mac.set_data;
                  bcnt_q  <= 3'd0;
                  csn_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (half_end) begin
                  state_q <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (half_end) begin
                  if (!sck_q) begin
                     // Rising SCK edge: slave data is sampled here.
                     sck_q   <= 1'b1;
                     rx_sr_q <= {rx_sr_q[6:0], cspi_miso};
                  end else begin
                     sck_q <= 1'b0;
                     // Last falling edge leaves bit0 on MOSI through HOLD.
                     if (bcnt_q == 3'd7) begin
                        state_q <= ST_HOLD;
                     end else begin
                        tx_sr_q <= {tx_sr_q[6:0], 1'b0};
                        bcnt_q  <= bcnt_q + 3'd1;
                     end
                  end
               end
            end
            ST_HOLD: begin
               if (half_end) begin
                  csn_q   <= 1'b1;
                  // Clearing the shifter drives MOSI low for GAP and IDLE.
                  tx_sr_q <= 8'h00;
                  state_q <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (half_end) begin
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               get_q_q <= rx_sr_q;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cspi_csn      = csn_q;
   assign cspi_sck      = sck_q;
   // MOSI is the shifter MSB; the shifter is a register, so the pin is glitch-free.
   assign cspi_mosi     = tx_sr_q[7];
   assign mac.done_cspi = done_q;
   assign mac.get_vld   = done_q;
   assign mac.get_q     = get_q_q;
   assign mac.busy      = busy_q;

endmodule

// File: tb/tb_arm_ctrl_cspi.sv
// Self-checking bench for arm_ctrl_cspi with a scoreboard of expected bytes and timing.
// Latency: n/a.
// Backpressure: n/a.
module tb_arm_ctrl_cspi;
   import arm_ctrl_pkg::*;

   localparam int D = 4;

   logic clk_sys = 1'b0;
   logic rst_n   = 1'b0;
   always #5 clk_sys = ~clk_sys;

   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   // main DUT, DIV=4
   arm_ctrl_cspi_if bus ();
   logic cspi_csn, cspi_sck, cspi_mosi, cspi_miso;

   arm_ctrl_cspi #(.DIV(D)) u_dut (
      .clk_sys   (clk_sys),
      .rst_n     (rst_n),
      .mac       (bus),
      .cspi_csn  (cspi_csn),
      .cspi_sck  (cspi_sck),
      .cspi_mosi (cspi_mosi),
      .cspi_miso (cspi_miso)
   );

   // divider corner instances, MISO tied high
   arm_ctrl_cspi_if bus2 ();
   arm_ctrl_cspi_if bus255 ();
   logic csn2, sck2, mosi2, csn255, sck255, mosi255;

   arm_ctrl_cspi #(.DIV(2)) u_dut2 (
      .clk_sys   (clk_sys),
      .rst_n     (rst_n),
      .mac       (bus2),
      .cspi_csn  (csn2),
      .cspi_sck  (sck2),
      .cspi_mosi (mosi2),
      .cspi_miso (1'b1)
   );

   arm_ctrl_cspi #(.DIV(255)) u_dut255 (
      .clk_sys   (clk_sys),
      .rst_n     (rst_n),
      .mac       (bus255),
      .cspi_csn  (csn255),
      .cspi_sck  (sck255),
      .cspi_mosi (mosi255),
      .cspi_miso (1'b1)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [7:0] tx;
      logic [7:0] rx;
      int         fire_cyc;
   } exp_t;

   exp_t sb_q[$];

   // monitor / slave state
   logic       prev_sck = 1'b0;
   logic       prev_csn = 1'b1;
   logic [7:0] mon_tx   = 8'h00;
   int         mon_bits = 0;
   int         csn_low  = 0;
   int         last_csn_low = 0;
   int         csn_high = 0;
   int         n_frames = 0;
   int         n_done   = 0;
   int         done_cyc = 0;
   logic       vld_d    = 1'b0;
   logic       gap_chk_en = 1'b0;
   logic [7:0] slave_next = 8'h00;
   logic [7:0] sreg = 8'h00;
   int         sbit = 0;
   exp_t       mon_e;

   initial cspi_miso = 1'b0;

   always @(negedge clk_sys) begin
      if (!rst_n) begin
         prev_sck = 1'b0;
         prev_csn = 1'b1;
         mon_bits = 0;
         csn_low  = 0;
         csn_high = 0;
         vld_d    = 1'b0;
         sbit     = 0;
         cspi_miso = 1'b0;
      end else begin
         // mode-0 slave: bit7 ready at CS fall, next bit after each SCK fall
         if (cspi_csn) begin
            sbit      = 0;
            sreg      = slave_next;
            cspi_miso = 1'b0;
         end else begin
            if (prev_sck && !cspi_sck) sbit++;
            if (sbit < 8) cspi_miso = sreg[7 - sbit];
         end

         if (!prev_sck && cspi_sck) begin
            mon_tx = {mon_tx[6:0], cspi_mosi};
            mon_bits++;
         end

         if (!cspi_csn) begin
            if (prev_csn) begin
               if (gap_chk_en && n_frames > 0) chk("cs_gap_min", 32'(csn_high >= D + 2), 32'd1);
               mon_bits = 0;
               csn_low  = 0;
            end
            csn_low++;
         end else begin
            if (!prev_csn) begin
               last_csn_low = csn_low;
               csn_high     = 0;
               n_frames++;
            end
            csn_high++;
         end

         // get_q is visible the cycle after the pulse
         if (vld_d) begin
            if (sb_q.size() == 0) begin
               chk("spurious_done", 32'd1, 32'd0);
            end else begin
               mon_e = sb_q.pop_front();
               chk("get_q", 32'(bus.get_q), 32'(mon_e.rx));
               chk("mosi_byte", 32'(mon_tx), 32'(mon_e.tx));
               chk("mosi_bits", 32'(mon_bits), 32'd8);
               chk("csn_low_cycles", 32'(last_csn_low), 32'(18 * D));
               chk("done_latency", 32'(done_cyc - mon_e.fire_cyc), 32'(1 + 19 * D));
            end
         end
         vld_d = bus.get_vld;
         if (bus.get_vld) begin
            done_cyc = cyc;
            n_done++;
            chk("done_with_vld", 32'(bus.done_cspi), 32'd1);
         end

         prev_sck = cspi_sck;
         prev_csn = cspi_csn;
      end
   end

   task automatic send(input logic [7:0] tx, input logic [7:0] rx, input bit track);
      exp_t e;
      slave_next = rx;
      @(negedge clk_sys);
      if (track) begin
         e.tx = tx;
         e.rx = rx;
         e.fire_cyc = cyc;
         sb_q.push_back(e);
      end
      bus.set_data  = tx;
      bus.fire_cspi = 1'b1;
      @(negedge clk_sys);
      bus.fire_cspi = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int k = 0;
      while (!bus.done_cspi && k < limit) begin
         @(negedge clk_sys);
         k++;
      end
      if (k >= limit) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk_sys);
   endtask

   logic [7:0] mac_bytes [5];
   int         f0, d0, c0, k;
   int         r2 [2];
   int         r255 [2];
   int         nr2, nr255, d2, d255;
   logic       ps2, ps255;

   initial begin
      bus.fire_cspi    = 1'b0;
      bus.set_data     = 8'h00;
      bus2.fire_cspi   = 1'b0;
      bus2.set_data    = 8'h00;
      bus255.fire_cspi = 1'b0;
      bus255.set_data  = 8'h00;
      mac_bytes = '{8'h01, 8'h02, 8'h10, 8'h55, MAC_TRAILER_BYTE};

      // reset values
      #22;
      chk("rst_csn", 32'(cspi_csn), 32'd1);
      chk("rst_sck", 32'(cspi_sck), 32'd0);
      chk("rst_mosi", 32'(cspi_mosi), 32'd0);
      chk("rst_done", 32'(bus.done_cspi), 32'd0);
      chk("rst_vld", 32'(bus.get_vld), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_get_q", 32'(bus.get_q), 32'd0);
      @(negedge clk_sys);
      rst_n = 1'b1;
      idle(3);

      // basic transfer
      send(8'hA5, 8'h3C, 1'b1);
      chk("busy_in_setup", 32'(bus.busy), 32'd1);
      wait_done(200);
      idle(3);

      // MAC command: five bytes, next fire two cycles after done
      gap_chk_en = 1'b1;
      f0 = n_frames;
      for (int i = 0; i < 5; i++) begin
         send(mac_bytes[i], 8'hC0 ^ 8'(i * 17), 1'b1);
         wait_done(200);
         @(negedge clk_sys);
      end
      idle(3);
      gap_chk_en = 1'b0;
      chk("mac_frames", 32'(n_frames - f0), 32'd5);
      chk("mac_sb_empty", 32'(sb_q.size()), 32'd0);

      // fires during SHIFT and during DONE are ignored
      d0 = n_done;
      send(8'h5A, 8'h96, 1'b1);
      k = 0;
      while (mon_bits < 3 && k < 200) begin
         @(negedge clk_sys);
         k++;
      end
      chk("reach_shift", 32'(k < 200), 32'd1);
      bus.set_data  = 8'h00;
      bus.fire_cspi = 1'b1;
      @(negedge clk_sys);
      bus.fire_cspi = 1'b0;
      wait_done(200);
      bus.fire_cspi = 1'b1;
      @(negedge clk_sys);
      bus.fire_cspi = 1'b0;
      idle(100);
      chk("ignored_fire_dones", 32'(n_done - d0), 32'd1);
      chk("ignored_fire_csn", 32'(cspi_csn), 32'd1);
      chk("ignored_fire_busy", 32'(bus.busy), 32'd0);

      // reset in the 4th bit
      d0 = n_done;
      send(8'h77, 8'h11, 1'b0);
      k = 0;
      while (mon_bits < 4 && k < 200) begin
         @(negedge clk_sys);
         k++;
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_csn", 32'(cspi_csn), 32'd1);
      chk("arst_sck", 32'(cspi_sck), 32'd0);
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_get_q", 32'(bus.get_q), 32'd0);
      chk("arst_done", 32'(bus.done_cspi), 32'd0);
      idle(3);
      rst_n = 1'b1;
      idle(2);
      send(8'hC3, 8'h5E, 1'b1);
      wait_done(200);
      idle(3);
      chk("post_rst_dones", 32'(n_done - d0), 32'd1);

      // DIV=2 and DIV=255, MISO tied high
      @(negedge clk_sys);
      c0 = cyc;
      bus2.set_data    = 8'h00;
      bus255.set_data  = 8'h00;
      bus2.fire_cspi   = 1'b1;
      bus255.fire_cspi = 1'b1;
      nr2 = 0; nr255 = 0; d2 = -1; d255 = -1;
      r2 = '{0, 0};
      r255 = '{0, 0};
      ps2 = 1'b0; ps255 = 1'b0;
      for (int j = 0; j < 6000 && (d2 < 0 || d255 < 0); j++) begin
         @(negedge clk_sys);
         bus2.fire_cspi   = 1'b0;
         bus255.fire_cspi = 1'b0;
         if (sck2 && !ps2 && nr2 < 2) begin
            r2[nr2] = cyc;
            nr2++;
         end
         if (sck255 && !ps255 && nr255 < 2) begin
            r255[nr255] = cyc;
            nr255++;
         end
         if (bus2.done_cspi && d2 < 0) d2 = cyc - c0;
         if (bus255.done_cspi && d255 < 0) d255 = cyc - c0;
         ps2   = sck2;
         ps255 = sck255;
      end
      @(negedge clk_sys);
      @(negedge clk_sys);
      chk("div2_first_rise", 32'(r2[0] - c0), 32'd5);
      chk("div2_sck_period", 32'(r2[1] - r2[0]), 32'd4);
      chk("div2_latency", 32'(d2), 32'd39);
      chk("div2_get_q", 32'(bus2.get_q), 32'hFF);
      chk("div255_sck_period", 32'(r255[1] - r255[0]), 32'd510);
      chk("div255_latency", 32'(d255), 32'd4846);
      chk("div255_get_q", 32'(bus255.get_q), 32'hFF);

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/arm_ctrl_cspi.md
# arm_ctrl_cspi

Byte-level CSPI master PHY that executes one 8-bit full-duplex SPI transfer (mode 0, MSB first) per `fire_cspi` pulse from the ARM-control MAC, which issues five such transfers per command (dev_id, mod_id, cmd_addr, cmd_data, 0xFF). Each transfer shifts `set_data` out on `cspi_mosi` while capturing `cspi_miso` into `get_q`. `done_cspi` is timed so that the MAC's next fire always lands in IDLE.

## Interface
- `DIV`, 4: SCK half-period in `clk_sys` cycles; legal range 2..255.
- `clk_sys` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `fire_cspi` in 1: single-cycle start strobe from the MAC; honoured only in IDLE.
- `set_data` in 8: byte to transmit; sampled on the edge where `fire_cspi` is accepted.
- `done_cspi` out 1: one-cycle pulse when the transfer and the CS gap are complete.
- `get_q` out 8: byte received on MISO; updated with `get_vld`, held otherwise.
- `get_vld` out 1: one-cycle pulse, coincident with `done_cspi`.
- `busy` out 1: high in every state except IDLE.
- `cspi_csn` out 1: chip select, active low.
- `cspi_sck` out 1: serial clock, idles low.
- `cspi_mosi` out 1: serial data out.
- `cspi_miso` in 1: serial data in; already synchronous to `clk_sys` (no synchroniser in this block).

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, GAP, DONE. An 8-bit divider counter `dcnt` counts 0..DIV-1 in every timed state.
- IDLE: `csn`=1, `sck`=0, `mosi`=0. On `fire_cspi`: latch `set_data` into `tx_sr`, clear `dcnt` and the 3-bit bit counter `bcnt`, go to SETUP.
- SETUP (DIV cycles): `csn`=0, `sck`=0, `mosi`=`tx_sr[7]`.
- SHIFT (16·DIV cycles, 8 bits): each bit is a low phase of DIV cycles followed by a high phase of DIV cycles.
  - MISO capture: on the edge that takes `sck` 0→1, `rx_sr <= {rx_sr[6:0], cspi_miso}`.
  - MOSI advance: on the edge that takes `sck` 1→0, `tx_sr` shifts left and `bcnt` increments.
  - After the 8th high phase, go to HOLD. No shift occurs on this exit, so `mosi` keeps bit0.
- HOLD (DIV cycles): `csn`=0, `sck`=0.
- GAP (DIV cycles): `csn`=1, `mosi`=0.
- DONE (1 cycle): `done_cspi`=1, `get_vld`=1, `get_q <= rx_sr` (visible the cycle after DONE and held until the next DONE). Next state is IDLE.
- `fire_cspi` outside IDLE is ignored; no queueing, no state change.
- Reset: `csn`=1, `sck`=0, `mosi`=0, `done_cspi`=0, `get_vld`=0, `busy`=0, `get_q`=0x00, state IDLE.
- Reset asserted mid-transfer forces these values immediately (asynchronously), `csn` included.

## Timing
- `fire_cspi` accepted in cycle t: SETUP covers t+1..t+DIV.
- First SCK rise occurs at t+1+2·DIV.
- `done_cspi` is high in cycle t+1+19·DIV (DIV=4: t+77).
- The MAC's WAIT→FIRE path puts the next fire at t+3+19·DIV, when this block is in IDLE. Back-to-back bytes therefore have a minimum CS-high time of DIV+2 cycles.
- SCK period is 2·DIV cycles, 50% duty. MOSI changes only while SCK is low, at least DIV cycles before the rising edge.
- `fire_cspi` coincident with DONE is ignored (state is not IDLE).

## Structure
- Shared package `arm_ctrl_pkg` holds:
  - state encoding localparams (IDLE=0, SETUP=1, SHIFT=2, HOLD=3, GAP=4, DONE=5);
  - `CSPI_DIV_DEF` = 4;
  - the MAC trailer byte constant 0xFF.
- One sub-module, `cspi_tick_gen`: the DIV counter. It produces `half_end` (last cycle of a half-period/phase) and takes a synchronous `clr` input. The FSM, shift registers and bit counter stay in `arm_ctrl_cspi`.

## Test plan
- DIV=4, fire with `set_data`=0xA5, slave returns 0x3C:
  - MOSI sampled at the 8 SCK rises reads 1010_0101;
  - `get_q`=0x3C after the `get_vld` pulse;
  - `done_cspi` exactly 77 cycles after fire;
  - `csn` low for exactly 72 cycles.
- Full MAC sequence 0x01, 0x02, 0x10, 0x55, 0xFF driven through `arm_ctrl_mac`:
  - five CS frames with the bytes in order;
  - no fire lost;
  - CS-high gap ≥ 6 cycles between frames.
- Fire pulses injected during SHIFT and during DONE: no effect on waveforms, no extra `done_cspi`.
- `rst_n` asserted in the 4th bit:
  - `csn`=1, `sck`=0, `busy`=0, `get_q`=0 in the same cycle, with no `done_cspi`;
  - after release, a 0xC3 transfer completes normally.
- DIV=2 and DIV=255 with MISO tied to 1: `get_q`=0xFF, SCK period 4 and 510 cycles respectively, done latency 39 and 4846 cycles.
